frog_move_ctrl: RTL and testbench

Input controller and move scheduler for the frog game. It debounces the four active-low direction switches and turns each clean press into one move event. When several directions are pending at once, it picks one by fixed priority. Each granted move goes to the VGA write/redraw datapath over a req/ack handshake, and the block keeps the frog's grid position clamped to the playfield.

---
 rtl/frog_move_ctrl_if.sv | 35 +++
 rtl/frog_move_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_frog_move_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frog_move_ctrl_if.sv
// -----------------------------------------------------------------------------
// frog_move_ctrl_if
// Move handshake between the frog move scheduler (master) and the VGA
// write/redraw datapath (slave).
//   move_req : a move is offered (master -> slave)
//   move_dir : 0=up, 1=down, 2=left, 3=right (master -> slave)
//   next_x   : target x, valid while move_req=1 (master -> slave)
//   next_y   : target y, valid while move_req=1 (master -> slave)
//   move_ack : datapath accepted the move (slave -> master)
// -----------------------------------------------------------------------------
interface frog_move_ctrl_if #(
    parameter int POS_W = 4
);
    logic             move_req;
    logic [1:0]       move_dir;
    logic [POS_W-1:0] next_x;
    logic [POS_W-1:0] next_y;
    logic             move_ack;

    modport master (
        output move_req,
        output move_dir,
        output next_x,
        output next_y,
        input  move_ack
    );

    modport slave (
        input  move_req,
        input  move_dir,
        input  next_x,
        input  next_y,
        output move_ack
    );
endinterface

// File: rtl/frog_move_ctrl.sv
// -----------------------------------------------------------------------------
// frog_move_ctrl
// Input controller and move scheduler for the frog game. Debounces the four
// active-low direction switches, turns each clean press into a pending move,
// grants pending moves by fixed priority (up > down > left > right), offers
// each legal move to the redraw datapath over a req/ack handshake and keeps
// the committed frog position inside the playfield.
// Ports:
//   clk       : system clock, rising edge
//   sw5       : asynchronous active-low reset
//   sw4/sw3   : up / down switch, raw, active-low
//   sw1/sw2   : left / right switch, raw, active-low
//   mv        : move handshake (master side)
//   frog_x/y  : committed frog position
//   hop_count : committed moves, saturating at 255
//   win       : one-cycle pulse when a move lands on row 0
// -----------------------------------------------------------------------------
module frog_move_ctrl #(
    parameter int DB_CYCLES = 3,
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int POS_W     = 4,
    parameter int START_X   = 8,
    parameter int START_Y   = 11
) (
    input  logic                  clk,
    input  logic                  sw5,
    input  logic                  sw4,
    input  logic                  sw3,
    input  logic                  sw1,
    input  logic                  sw2,
    frog_move_ctrl_if.master      mv,
    output logic [POS_W-1:0]      frog_x,
    output logic [POS_W-1:0]      frog_y,
    output logic [7:0]            hop_count,
    output logic                  win
);
    localparam int               CNT_W     = $clog2(DB_CYCLES + 1);
    localparam logic [POS_W:0]   LP_ONE    = 1;
    localparam logic [POS_W:0]   LP_GRID_W = (POS_W+1)'(GRID_W);
    localparam logic [POS_W:0]   LP_GRID_H = (POS_W+1)'(GRID_H);
    localparam logic [POS_W-1:0] LP_STX    = POS_W'(START_X);
    localparam logic [POS_W-1:0] LP_STY    = POS_W'(START_Y);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    // Direction index order: 0=up, 1=down, 2=left, 3=right.
    logic [3:0] w_sw_raw;
    logic [3:0] w_press;
    logic [3:0] w_clr;
    logic [3:0] r_pend;

    assign w_sw_raw = {sw2, sw1, sw3, sw4};

    // Per-switch 2-flop synchronizer, debouncer and rising-edge detector.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sw
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic             r_stable_d;
            logic [CNT_W-1:0] r_cnt;
            logic             w_level;

            assign w_level     = ~r_sync2;
            assign w_press[gi] = r_stable & ~r_stable_d;

            always_ff @(posedge clk or negedge sw5) begin
                if (!sw5) begin
                    r_sync1    <= 1'b1;
                    r_sync2    <= 1'b1;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_sw_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (w_level != r_stable) begin
                        // The edge on which the count would reach DB_CYCLES flips the level.
                        if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                            r_stable <= w_level;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end
        end
    endgenerate

    // A press on the same edge as a clear keeps the bit set.
    always_ff @(posedge clk or negedge sw5) begin
        if (!sw5) r_pend <= '0;
        else      r_pend <= (r_pend & ~w_clr) | w_press;
    end

    // ---------------- move scheduler FSM ----------------
    state_t           r_state, r_state_next;
    logic             r_move_req, r_move_req_next;
    logic [1:0]       r_move_dir, r_move_dir_next;
    logic [POS_W-1:0] r_next_x, r_next_x_next;
    logic [POS_W-1:0] r_next_y, r_next_y_next;
    logic [POS_W-1:0] r_frog_x, r_frog_x_next;
    logic [POS_W-1:0] r_frog_y, r_frog_y_next;
    logic [7:0]       r_hop, r_hop_next;
    logic             r_win, r_win_next;

    logic [1:0]       w_sel;
    logic [POS_W:0]   w_x_inc;
    logic [POS_W:0]   w_y_inc;
    logic [POS_W-1:0] w_tx;
    logic [POS_W-1:0] w_ty;
    logic             w_legal;

    assign w_x_inc = {1'b0, r_frog_x} + LP_ONE;
    assign w_y_inc = {1'b0, r_frog_y} + LP_ONE;

    always_ff @(posedge clk or negedge sw5) begin
        if (!sw5) begin
            r_state    <= ST_IDLE;
            r_move_req <= 1'b0;
            r_move_dir <= 2'd0;
            r_next_x   <= LP_STX;
            r_next_y   <= LP_STY;
            r_frog_x   <= LP_STX;
            r_frog_y   <= LP_STY;
            r_hop      <= 8'd0;
            r_win      <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_move_req <= r_move_req_next;
            r_move_dir <= r_move_dir_next;
            r_next_x   <= r_next_x_next;
            r_next_y   <= r_next_y_next;
            r_frog_x   <= r_frog_x_next;
            r_frog_y   <= r_frog_y_next;
            r_hop      <= r_hop_next;
            r_win      <= r_win_next;
        end
    end

    always_comb begin
        r_state_next    = r_state;
        r_move_req_next = r_move_req;
        r_move_dir_next = r_move_dir;
        r_next_x_next   = r_next_x;
        r_next_y_next   = r_next_y;
        r_frog_x_next   = r_frog_x;
        r_frog_y_next   = r_frog_y;
        r_hop_next      = r_hop;
        r_win_next      = 1'b0;
        w_clr           = 4'b0000;

        // Fixed priority pick among pending directions.
        if      (r_pend[0]) w_sel = 2'd0;
        else if (r_pend[1]) w_sel = 2'd1;
        else if (r_pend[2]) w_sel = 2'd2;
        else                w_sel = 2'd3;

        w_tx = r_frog_x;
        w_ty = r_frog_y;
        case (w_sel)
            2'd0: begin w_ty = r_frog_y - 1'b1;       w_legal = (r_frog_y != '0);      end
            2'd1: begin w_ty = w_y_inc[POS_W-1:0];    w_legal = (w_y_inc < LP_GRID_H); end
            2'd2: begin w_tx = r_frog_x - 1'b1;       w_legal = (r_frog_x != '0);      end
            default: begin w_tx = w_x_inc[POS_W-1:0]; w_legal = (w_x_inc < LP_GRID_W); end
        endcase

        case (r_state)
            ST_IDLE: begin
                if (r_pend != 4'b0000) begin
                    if (w_legal) begin
                        r_move_req_next = 1'b1;
                        r_move_dir_next = w_sel;
                        r_next_x_next   = w_tx;
                        r_next_y_next   = w_ty;
                        r_state_next    = ST_REQ;
                    end else begin
                        // Off-grid move: drop it and spend this cycle doing so.
                        w_clr[w_sel] = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mv.move_ack) begin
                    w_clr[r_move_dir] = 1'b1;
                    r_move_req_next   = 1'b0;
                    r_state_next      = ST_IDLE;
                    if (r_hop != 8'hFF) r_hop_next = r_hop + 8'd1;
                    if (r_next_y == '0) begin
                        // Reaching the goal row restarts the frog.
                        r_win_next    = 1'b1;
                        r_frog_x_next = LP_STX;
                        r_frog_y_next = LP_STY;
                    end else begin
                        r_frog_x_next = r_next_x;
                        r_frog_y_next = r_next_y;
                    end
                end
            end
            default: r_state_next = ST_IDLE;
        endcase
    end

    assign mv.move_req = r_move_req;
    assign mv.move_dir = r_move_dir;
    assign mv.next_x   = r_next_x;
    assign mv.next_y   = r_next_y;
    assign frog_x      = r_frog_x;
    assign frog_y      = r_frog_y;
    assign hop_count   = r_hop;
    assign win         = r_win;
endmodule

// File: tb/tb_frog_move_ctrl.sv
module tb_frog_move_ctrl;
    localparam int DB = 3, GW = 16, GH = 12, PW = 4, SX = 8, SY = 11;

    logic clk = 1'b0;
    logic sw5 = 1'b0, sw4 = 1'b1, sw3 = 1'b1, sw1 = 1'b1, sw2 = 1'b1;
    logic [PW-1:0] frog_x, frog_y;
    logic [7:0]    hop_count;
    logic          win;

    frog_move_ctrl_if #(.POS_W(PW)) mv();

    frog_move_ctrl #(
        .DB_CYCLES(DB), .GRID_W(GW), .GRID_H(GH),
        .POS_W(PW), .START_X(SX), .START_Y(SY)
    ) dut (
        .clk(clk), .sw5(sw5), .sw4(sw4), .sw3(sw3), .sw1(sw1), .sw2(sw2),
        .mv(mv), .frog_x(frog_x), .frog_y(frog_y),
        .hop_count(hop_count), .win(win)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (transaction level)
    int m_x, m_y, m_hop, m_wins;
    int e_dir[$], e_x[$], e_y[$];

    // Observations from the last run_press
    int g_dir[$], g_x[$], g_y[$];
    int g_lat, g_win_cycles, g_err;

    task automatic tick();
        @(negedge clk);
    endtask

    // mask bits: 0=up(sw4) 1=down(sw3) 2=left(sw1) 3=right(sw2), active-high
    task automatic set_sw(input logic [3:0] m);
        sw4 = ~m[0]; sw3 = ~m[1]; sw1 = ~m[2]; sw2 = ~m[3];
    endtask

    task automatic do_reset();
        sw5 = 1'b0; set_sw(4'b0000); mv.move_ack = 1'b0;
        repeat (3) tick();
        sw5 = 1'b1;
        tick();
        m_x = SX; m_y = SY; m_hop = 0; m_wins = 0;
    endtask

    // Expected grants for a set of simultaneous presses, from the game rules.
    task automatic model_press(input logic [3:0] mask);
        int tx, ty;
        e_dir.delete(); e_x.delete(); e_y.delete();
        for (int d = 0; d < 4; d++) begin
            if (mask[d]) begin
                tx = m_x; ty = m_y;
                if (d == 0) ty = ty - 1;
                else if (d == 1) ty = ty + 1;
                else if (d == 2) tx = tx - 1;
                else tx = tx + 1;
                if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
                    e_dir.push_back(d); e_x.push_back(tx); e_y.push_back(ty);
                    m_hop = (m_hop < 255) ? m_hop + 1 : 255;
                    if (ty == 0) begin m_wins++; m_x = SX; m_y = SY; end
                    else begin m_x = tx; m_y = ty; end
                end
            end
        end
    endtask

    // Hold the mask for 'hold' cycles, act as the redraw datapath (ack after
    // ack_dly cycles of req) and record every grant within 'window' cycles.
    task automatic run_press(input logic [3:0] mask, input int hold,
                             input int ack_dly, input int window);
        logic prev = 1'b0;
        int cnt = 0;
        g_dir.delete(); g_x.delete(); g_y.delete();
        g_lat = -1; g_win_cycles = 0; g_err = 0;
        set_sw(mask);
        for (int c = 1; c <= window; c++) begin
            tick();
            if (win === 1'b1) g_win_cycles++;
            if (mv.move_ack === 1'b1) begin
                mv.move_ack = 1'b0;
                if (mv.move_req !== 1'b0) g_err++;
            end else if (mv.move_req === 1'b1) begin
                if (!prev) begin
                    g_dir.push_back(int'(mv.move_dir));
                    g_x.push_back(int'(mv.next_x));
                    g_y.push_back(int'(mv.next_y));
                    if (g_lat < 0) g_lat = c;
                    cnt = 0;
                    $display("[TB] grant dir=%0d next=(%0d,%0d) cycle=%0d", mv.move_dir, mv.next_x, mv.next_y, c);
                end else if (int'(mv.move_dir) != g_dir[$] || int'(mv.next_x) != g_x[$] || int'(mv.next_y) != g_y[$]) begin
                    g_err++;
                end
                if (cnt >= ack_dly) mv.move_ack = 1'b1;
                else cnt++;
            end
            prev = mv.move_req;
            if (c == hold) set_sw(4'b0000);
        end
        mv.move_ack = 1'b0;
    endtask

    task automatic test_reset();
        sw5 = 1'b0; set_sw(4'b0000); mv.move_ack = 1'b0;
        repeat (3) tick();
        n_tests++; if (mv.move_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_in_reset: got %0b expected 0", mv.move_req); end
        sw5 = 1'b1;
        repeat (50) tick();
        n_tests++; if (mv.move_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", mv.move_req); end
        n_tests++; if (frog_x !== PW'(SX) || frog_y !== PW'(SY)) begin n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (%0d,%0d)", frog_x, frog_y, SX, SY); end
        n_tests++; if (mv.next_x !== PW'(SX) || mv.next_y !== PW'(SY)) begin n_fail++; $display("FAIL reset_next: got (%0d,%0d) expected (%0d,%0d)", mv.next_x, mv.next_y, SX, SY); end
        n_tests++; if (hop_count !== 8'd0 || win !== 1'b0 || mv.move_dir !== 2'd0) begin n_fail++; $display("FAIL reset_misc: got hop=%0d win=%0b dir=%0d expected 0 0 0", hop_count, win, mv.move_dir); end
        $display("[TB] reset check done");
    endtask

    task automatic test_latency();
        do_reset();
        run_press(4'b0001, 10, 2, 30);
        n_tests++; if (g_dir.size() != 1) begin n_fail++; $display("FAIL lat_grants: got %0d expected 1", g_dir.size()); end
        n_tests++; if (g_lat != DB + 4) begin n_fail++; $display("FAIL lat_cycles: got %0d expected %0d", g_lat, DB + 4); end
        if (g_dir.size() > 0) begin
            n_tests++; if (g_dir[0] != 0 || g_x[0] != 8 || g_y[0] != 10) begin n_fail++; $display("FAIL lat_target: got dir=%0d (%0d,%0d) expected dir=0 (8,10)", g_dir[0], g_x[0], g_y[0]); end
        end
        n_tests++; if (frog_x !== 4'd8 || frog_y !== 4'd10 || hop_count !== 8'd1) begin n_fail++; $display("FAIL lat_commit: got (%0d,%0d) hop=%0d expected (8,10) hop=1", frog_x, frog_y, hop_count); end
        n_tests++; if (g_err != 0) begin n_fail++; $display("FAIL lat_handshake: got %0d errors expected 0", g_err); end
    endtask

    task automatic test_glitch();
        int nreq = 0;
        for (int r = 0; r < 4; r++) begin
            set_sw(4'b0100);
            repeat (2) begin tick(); if (mv.move_req !== 1'b0) nreq++; end
            set_sw(4'b0000);
            repeat (4) begin tick(); if (mv.move_req !== 1'b0) nreq++; end
        end
        repeat (10) begin tick(); if (mv.move_req !== 1'b0) nreq++; end
        $display("[TB] glitch burst done");
        n_tests++; if (nreq != 0) begin n_fail++; $display("FAIL glitch_req: got %0d req cycles expected 0", nreq); end
        n_tests++; if (frog_x !== 4'd8 || frog_y !== 4'd10 || hop_count !== 8'd1) begin n_fail++; $display("FAIL glitch_state: got (%0d,%0d) hop=%0d expected (8,10) hop=1", frog_x, frog_y, hop_count); end
    endtask

    task automatic test_priority();
        do_reset();
        run_press(4'b0101, 5, 0, 40);
        n_tests++; if (g_dir.size() != 2) begin n_fail++; $display("FAIL prio_grants: got %0d expected 2", g_dir.size()); end
        if (g_dir.size() == 2) begin
            n_tests++; if (g_dir[0] != 0 || g_dir[1] != 2) begin n_fail++; $display("FAIL prio_order: got %0d,%0d expected 0,2", g_dir[0], g_dir[1]); end
            n_tests++; if (g_x[1] != 7 || g_y[1] != 10) begin n_fail++; $display("FAIL prio_target2: got (%0d,%0d) expected (7,10)", g_x[1], g_y[1]); end
        end
        n_tests++; if (frog_x !== 4'd7 || frog_y !== 4'd10 || hop_count !== 8'd2) begin n_fail++; $display("FAIL prio_commit: got (%0d,%0d) hop=%0d expected (7,10) hop=2", frog_x, frog_y, hop_count); end
        n_tests++; if (g_err != 0) begin n_fail++; $display("FAIL prio_handshake: got %0d errors expected 0", g_err); end
    endtask

    task automatic test_drop_down();
        do_reset();
        run_press(4'b0010, 5, 0, 25);
        n_tests++; if (g_dir.size() != 0) begin n_fail++; $display("FAIL drop_grants: got %0d expected 0", g_dir.size()); end
        n_tests++; if (frog_x !== 4'd8 || frog_y !== 4'd11 || hop_count !== 8'd0) begin n_fail++; $display("FAIL drop_state: got (%0d,%0d) hop=%0d expected (8,11) hop=0", frog_x, frog_y, hop_count); end
        run_press(4'b0001, 5, 0, 25);
        n_tests++; if (g_dir.size() != 1) begin n_fail++; $display("FAIL drop_after_grants: got %0d expected 1", g_dir.size()); end
        n_tests++; if (frog_y !== 4'd10 || hop_count !== 8'd1) begin n_fail++; $display("FAIL drop_after_state: got y=%0d hop=%0d expected y=10 hop=1", frog_y, hop_count); end
    endtask

    task automatic test_left_edge();
        int total = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_press(4'b0100, 4, 1, 20);
            total += g_dir.size();
        end
        n_tests++; if (total != 8) begin n_fail++; $display("FAIL edge_grants: got %0d expected 8", total); end
        n_tests++; if (g_dir.size() != 0) begin n_fail++; $display("FAIL edge_last_dropped: got %0d grants expected 0", g_dir.size()); end
        n_tests++; if (frog_x !== 4'd0 || frog_y !== 4'd11 || hop_count !== 8'd8) begin n_fail++; $display("FAIL edge_state: got (%0d,%0d) hop=%0d expected (0,11) hop=8", frog_x, frog_y, hop_count); end
    endtask

    task automatic test_win();
        int wins = 0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_press(4'b0001, 5, int'($urandom_range(0, 3)), 25);
            wins += g_win_cycles;
        end
        n_tests++; if (wins != 1 || g_win_cycles != 1) begin n_fail++; $display("FAIL win_pulse: got total=%0d last=%0d expected 1 1", wins, g_win_cycles); end
        n_tests++; if (frog_x !== 4'd8 || frog_y !== 4'd11 || hop_count !== 8'd11) begin n_fail++; $display("FAIL win_state: got (%0d,%0d) hop=%0d expected (8,11) hop=11", frog_x, frog_y, hop_count); end
    endtask

    task automatic test_reset_in_req();
        bit seen = 1'b0;
        do_reset();
        set_sw(4'b0001);
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (mv.move_req === 1'b1) seen = 1'b1;
        end
        set_sw(4'b0000);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rstreq_timeout: got no req expected req within 20 cycles"); end
        #2 sw5 = 1'b0;
        #1;
        n_tests++; if (mv.move_req !== 1'b0) begin n_fail++; $display("FAIL rstreq_async: got %0b expected 0", mv.move_req); end
        tick(); tick();
        sw5 = 1'b1;
        repeat (20) tick();
        n_tests++; if (mv.move_req !== 1'b0 || frog_x !== 4'd8 || frog_y !== 4'd11 || hop_count !== 8'd0) begin n_fail++; $display("FAIL rstreq_state: got req=%0b (%0d,%0d) hop=%0d expected 0 (8,11) 0", mv.move_req, frog_x, frog_y, hop_count); end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        int hold, wins_before, bad;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(1, 15));
            wins_before = m_wins;
            if ($urandom_range(0, 3) == 0) begin
                hold = int'($urandom_range(1, 2));
                e_dir.delete(); e_x.delete(); e_y.delete();
            end else begin
                hold = int'($urandom_range(4, 8));
                model_press(mask);
            end
            run_press(mask, hold, int'($urandom_range(0, 3)), 50);
            n_tests++; if (g_dir.size() != e_dir.size()) begin n_fail++; $display("FAIL rand_grants[%0d]: got %0d expected %0d (mask=%b)", it, g_dir.size(), e_dir.size(), mask); end
            else begin
                bad = 0;
                foreach (e_dir[k]) if (g_dir[k] != e_dir[k] || g_x[k] != e_x[k] || g_y[k] != e_y[k]) bad++;
                n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_targets[%0d]: got %0d wrong grants expected 0 (mask=%b)", it, bad, mask); end
            end
            n_tests++; if (int'(frog_x) != m_x || int'(frog_y) != m_y || int'(hop_count) != m_hop) begin n_fail++; $display("FAIL rand_state[%0d]: got (%0d,%0d) hop=%0d expected (%0d,%0d) hop=%0d", it, frog_x, frog_y, hop_count, m_x, m_y, m_hop); end
            n_tests++; if (g_win_cycles != m_wins - wins_before || g_err != 0) begin n_fail++; $display("FAIL rand_win_hs[%0d]: got win=%0d err=%0d expected win=%0d err=0", it, g_win_cycles, g_err, m_wins - wins_before); end
        end
    endtask

    initial begin
        mv.move_ack = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_priority();
        test_drop_down();
        test_left_edge();
        test_win();
        test_reset_in_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
